// File: rtl/tonegen_pkg.sv
// Shared constants and sizing helpers for the multi-channel tone generator.
package tonegen_pkg;

    localparam int HALFPER_OFS  = 0;
    localparam int DURATION_OFS = 1;

    function automatic int ms_div(input int fclk);
        return fclk / 1000;
    endfunction

    function automatic int addr_w(input int nch);
        return (nch < 1) ? 1 : $clog2(2 * nch);
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tonegen_channel.sv
// One square-wave tone channel: half-period divider plus optional
// millisecond duration timer that silences the channel on expiry.
module tonegen_channel
    import tonegen_pkg::*;
#(
    parameter int DIVW = 24,
    parameter int DURW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_halfper,
    input  logic            wr_duration,
    input  logic [31:0]     wdata,
    input  logic            ms_tick,
    output logic            phase,
    output logic [DIVW-1:0] halfper,
    output logic [DURW-1:0] remaining,
    output logic            timed
);

    logic [DIVW-1:0] cnt;
    logic [DIVW-1:0] wd_hp;
    logic [DURW-1:0] wd_dur;
    logic            tick_ok;
    logic            expire;
    logic            unused_wdata;

    assign wd_hp        = wdata[DIVW-1:0];
    assign wd_dur       = wdata[DURW-1:0];
    assign unused_wdata = ^wdata;

    // Any bus write to this channel swallows a coincident tick.
    assign tick_ok = ms_tick && timed && (remaining != '0)
                   && !wr_halfper && !wr_duration;
    assign expire  = tick_ok && (remaining == DURW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            halfper <= '0;
            cnt     <= '0;
            phase   <= 1'b0;
        end else if (wr_halfper) begin
            halfper <= wd_hp;
            if (wd_hp != '0) begin
                cnt <= wd_hp - DIVW'(1);
            end else begin
                phase <= 1'b0;
            end
        end else if (expire) begin
            halfper <= '0;
            phase   <= 1'b0;
        end else if (halfper != '0) begin
            if (cnt == '0) begin
                phase <= ~phase;
                cnt   <= halfper - DIVW'(1);
            end else begin
                cnt <= cnt - DIVW'(1);
            end
        end else begin
            phase <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            remaining <= '0;
            timed     <= 1'b0;
        end else if (wr_duration) begin
            remaining <= wd_dur;
            timed     <= (wd_dur != '0);
        end else if (tick_ok) begin
            remaining <= remaining - DURW'(1);
            if (expire) begin
                timed <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tonegen_multi.sv
// NCH-channel Avalon-MM tone generator with a shared ms prescaler.
// Define TONEGEN_SIGMA_DELTA_MIX_EN for a PDM mix instead of OR mix.
module tonegen_multi
    import tonegen_pkg::*;
#(
    parameter int FCLK = 50000000,
    parameter int NCH  = 4,
    parameter int DIVW = 24,
    parameter int DURW = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [addr_w(NCH)-1:0] avs_address,
    input  logic                   avs_write,
    input  logic [31:0]            avs_writedata,
    input  logic                   avs_read,
    output logic [31:0]            avs_readdata,
    output logic [NCH-1:0]         coe_spkr,
    output logic                   coe_mix
);

    localparam int AW    = addr_w(NCH);
    localparam int MSDIV = ms_div(FCLK);
    localparam int PW    = cnt_w(MSDIV);

    logic [PW-1:0]   pre;
    logic            ms_tick;
    logic [NCH-1:0]  phase;
    logic [NCH-1:0]  timed;
    logic [NCH-1:0]  wr_hp;
    logic [NCH-1:0]  wr_dur;
    logic [DIVW-1:0] halfper   [NCH];
    logic [DURW-1:0] remaining [NCH];
    logic [31:0]     rd_mux;

    assign ms_tick = (pre == PW'(MSDIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            pre <= '0;
        end else if (ms_tick) begin
            pre <= '0;
        end else begin
            pre <= pre + PW'(1);
        end
    end

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        assign wr_hp[ch]  = avs_write
                         && (avs_address == AW'(2 * ch + HALFPER_OFS));
        assign wr_dur[ch] = avs_write
                         && (avs_address == AW'(2 * ch + DURATION_OFS));

        tonegen_channel #(
            .DIVW (DIVW),
            .DURW (DURW)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .wr_halfper  (wr_hp[ch]),
            .wr_duration (wr_dur[ch]),
            .wdata       (avs_writedata),
            .ms_tick     (ms_tick),
            .phase       (phase[ch]),
            .halfper     (halfper[ch]),
            .remaining   (remaining[ch]),
            .timed       (timed[ch])
        );
    end

    // Addresses past the last channel fall through to zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NCH; i++) begin
            if (avs_address == AW'(2 * i + HALFPER_OFS)) begin
                rd_mux = 32'(halfper[i]);
            end
            if (avs_address == AW'(2 * i + DURATION_OFS)) begin
                rd_mux     = 32'(remaining[i]);
                rd_mux[31] = timed[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            avs_readdata <= rd_mux;
        end
    end

    assign coe_spkr = phase;

`ifdef TONEGEN_SIGMA_DELTA_MIX_EN
    localparam int SW = $clog2(NCH) + 1;

    logic [SW-1:0] acc;
    logic [SW-1:0] sum;
    logic [SW:0]   acc_sum;

    always_comb begin
        sum = '0;
        for (int i = 0; i < NCH; i++) begin
            sum = sum + SW'(phase[i]);
        end
    end

    assign acc_sum = {1'b0, acc} + {1'b0, sum};

    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            coe_mix <= 1'b0;
        end else if (acc_sum >= (SW + 1)'(NCH)) begin
            acc     <= SW'(acc_sum - (SW + 1)'(NCH));
            coe_mix <= 1'b1;
        end else begin
            acc     <= SW'(acc_sum);
            coe_mix <= 1'b0;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            coe_mix <= 1'b0;
        end else begin
            coe_mix <= |phase;
        end
    end
`endif

endmodule

// File: tb/tb_tonegen_multi.sv
// Bench for tonegen_multi: register table, directed corner cases and
// random traffic against an arithmetic timeline model.
module tb_tonegen_multi;

    localparam int NCH  = 4;
    localparam int FCLK = 100000;
    localparam int DIVW = 24;
    localparam int DURW = 16;
    localparam int MS   = 100;
    localparam int AW   = 3;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [31:0]   exp;
    } vec_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [AW-1:0]  avs_address = '0;
    logic           avs_write = 1'b0;
    logic [31:0]    avs_writedata = '0;
    logic           avs_read = 1'b0;
    logic [31:0]    avs_readdata;
    logic [NCH-1:0] coe_spkr;
    logic           coe_mix;

    int cyc;
    int errors = 0;
    int checks = 0;

    int m_hp   [NCH];
    int m_hpw  [NCH];
    int m_ph0  [NCH];
    int m_dur  [NCH];
    int m_durw [NCH];
    bit m_timed[NCH];

    tonegen_multi #(
        .FCLK (FCLK),
        .NCH  (NCH),
        .DIVW (DIVW),
        .DURW (DURW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .coe_spkr      (coe_spkr),
        .coe_mix       (coe_mix)
    );

    always #5 clk = ~clk;

    // Edges since the last reset edge; the ms tick lands on multiples of MS.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %h expected %h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        step();
        avs_write     = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read    = 1'b1;
        step();
        avs_read    = 1'b0;
        d           = avs_readdata;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    function automatic int m_expiry(input int ch);
        return (m_durw[ch] / MS + m_dur[ch]) * MS;
    endfunction

    function automatic bit m_phase(input int ch, input int e);
        if (m_hp[ch] == 0) return 1'b0;
        if (m_timed[ch] && e >= m_expiry(ch)) return 1'b0;
        return 1'(m_ph0[ch] ^ (((e - m_hpw[ch]) / m_hp[ch]) & 1));
    endfunction

    function automatic void m_settle(input int ch, input int e);
        if (m_timed[ch] && e >= m_expiry(ch)) begin
            m_hp[ch]    = 0;
            m_timed[ch] = 1'b0;
            m_dur[ch]   = 0;
        end
    endfunction

    function automatic logic [31:0] m_read(input int a, input int e);
        int ch;
        ch = a / 2;
        if (m_timed[ch] && e >= m_expiry(ch)) return 32'h0;
        if (a % 2 == 0) return 32'(m_hp[ch]);
        if (!m_timed[ch]) return 32'(m_dur[ch]);
        return 32'h8000_0000
             | 32'(m_dur[ch] - (e / MS - m_durw[ch] / MS));
    endfunction

    function automatic void m_write(input int a, input logic [31:0] d,
                                    input int w);
        int ch;
        ch = a / 2;
        m_settle(ch, w);
        if (a % 2 == 0) begin
            m_ph0[ch] = int'(m_phase(ch, w - 1));
            m_hp[ch]  = int'(d & 32'h00FF_FFFF);
            m_hpw[ch] = w;
        end else begin
            m_dur[ch]   = int'(d & 32'h0000_FFFF);
            m_timed[ch] = (m_dur[ch] != 0);
            m_durw[ch]  = w;
        end
    endfunction

    initial begin
        vec_t           vecs[8];
        logic [31:0]    rd;
        logic [31:0]    exp_rd;
        logic [31:0]    wd;
        logic [NCH-1:0] exp_ph;
        logic [NCH-1:0] prev;
        logic           exp_mix;
        int             w;
        int             e;
        int             r;
        int             a;
        int             highs;
        int             acc_m;
        bit             seen;
        bit             rd_pend;

        vecs[0] = '{3'd0, 32'h0012_3456, 32'h0012_3456};
        vecs[1] = '{3'd2, 32'hFFFF_FFFF, 32'h00FF_FFFF};
        vecs[2] = '{3'd7, 32'h0001_2345, 32'h8000_2345};
        vecs[3] = '{3'd1, 32'h0000_0000, 32'h0000_0000};
        vecs[4] = '{3'd5, 32'hFFFF_0005, 32'h8000_0005};
        vecs[5] = '{3'd6, 32'h0000_0001, 32'h0000_0001};
        vecs[6] = '{3'd3, 32'h0001_0000, 32'h0000_0000};
        vecs[7] = '{3'd4, 32'h0000_0000, 32'h0000_0000};

        step();
        do_reset();

        check("reset_spkr", 32'(coe_spkr), 32'h0);
        check("reset_mix", 32'(coe_mix), 32'h0);
        check("reset_rdata", avs_readdata, 32'h0);
        do_read(3'd0, rd);
        check("reset_read0", rd, 32'h0);

        for (int i = 0; i < 8; i++) begin
            do_write(vecs[i].addr, vecs[i].wdata);
            do_read(vecs[i].addr, rd);
            check($sformatf("table[%0d]", i), rd, vecs[i].exp);
        end

        do_reset();
        do_write(3'd0, 32'd5);
        w = cyc;
        for (int k = 1; k <= 30; k++) begin
            step();
            check($sformatf("hp5_k%0d", cyc - w), 32'(coe_spkr),
                  32'(((cyc - w) / 5) & 1));
        end

        do_write(3'd2, 32'd7);
        do_write(3'd3, 32'd3);
        w     = cyc;
        seen  = 1'b0;
        highs = 0;
        for (int k = 1; k <= 320; k++) begin
            step();
            if (k >= 187 && k <= 200 && coe_spkr[1]) seen = 1'b1;
            if (k >= 301 && coe_spkr[1]) highs++;
        end
        check("dur_alive_at_200", 32'(seen), 32'h1);
        check("dur_silent_by_300", 32'(highs), 32'h0);
        do_read(3'd2, rd);
        check("dur_hp_cleared", rd, 32'h0);
        do_read(3'd3, rd);
        check("dur_reg_cleared", rd, 32'h0);

        do_write(3'd4, 32'd1);
        w = cyc;
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("hp1_k%0d", k), 32'(coe_spkr[2]), 32'(k & 1));
        end

        for (int k = 0; k < 2 * MS && ((cyc + 1) % MS) != 0; k++) step();
        check("tick_align", 32'((cyc + 1) % MS), 32'h0);
        do_write(3'd5, 32'd10);
        do_read(3'd5, rd);
        check("tick_write_wins", rd, 32'h8000_000A);
        repeat (MS - 1) step();
        do_read(3'd5, rd);
        check("tick_next_decr", rd, 32'h8000_0009);

        do_write(3'd6, 32'd4);
        do_write(3'd7, 32'd5);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (coe_spkr[3]) seen = 1'b1;
        end
        check("mid_tone_running", 32'(seen), 32'h1);
        do_reset();
        check("rst_mid_spkr", 32'(coe_spkr), 32'h0);
        check("rst_mid_mix", 32'(coe_mix), 32'h0);
        check("rst_mid_rdata", avs_readdata, 32'h0);
        for (int i = 0; i < 2 * NCH; i++) begin
            do_read(AW'(i), rd);
            check($sformatf("rst_mid_reg%0d", i), rd, 32'h0);
        end
        highs = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (coe_spkr != '0 || coe_mix) highs++;
        end
        check("rst_mid_quiet", 32'(highs), 32'h0);

        do_reset();
        for (int ch = 0; ch < NCH; ch++) begin
            m_hp[ch]    = 0;
            m_hpw[ch]   = 0;
            m_ph0[ch]   = 0;
            m_dur[ch]   = 0;
            m_durw[ch]  = 0;
            m_timed[ch] = 1'b0;
        end
        prev  = '0;
        acc_m = 0;
        for (int it = 0; it < 3000; it++) begin
            e         = cyc + 1;
            r         = $urandom_range(0, 9);
            rd_pend   = 1'b0;
            exp_rd    = '0;
            a         = $urandom_range(0, 2 * NCH - 1);
            avs_write = 1'b0;
            avs_read  = 1'b0;
            wd        = '0;
            if (r < 2 && (e % MS) != 0) begin
                if (a % 2 == 0) begin
                    wd = ($urandom_range(0, 3) == 0) ? 32'h0
                       : 32'($urandom_range(1, 12));
                    wd = wd | ($urandom & 32'hFF00_0000);
                end else begin
                    wd = 32'($urandom_range(0, 3));
                    wd = wd | ($urandom & 32'hFFFF_0000);
                end
                avs_address   = AW'(a);
                avs_writedata = wd;
                avs_write     = 1'b1;
            end else if (r < 4) begin
                exp_rd      = m_read(a, e - 1);
                rd_pend     = 1'b1;
                avs_address = AW'(a);
                avs_read    = 1'b1;
            end
            step();
            if (avs_write) m_write(a, wd, e);
            avs_write = 1'b0;
            avs_read  = 1'b0;
            for (int ch = 0; ch < NCH; ch++) exp_ph[ch] = m_phase(ch, e);
`ifdef TONEGEN_SIGMA_DELTA_MIX_EN
            acc_m = acc_m + $countones(prev);
            if (acc_m >= NCH) begin
                exp_mix = 1'b1;
                acc_m   = acc_m - NCH;
            end else begin
                exp_mix = 1'b0;
            end
`else
            exp_mix = |prev;
`endif
            check("rand_spkr", 32'(coe_spkr), 32'(exp_ph));
            check("rand_mix", 32'(coe_mix), 32'(exp_mix));
            if (rd_pend) check($sformatf("rand_read%0d", a), avs_readdata, exp_rd);
            prev = exp_ph;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
